// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell
// Optional signed overflow output: define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic x, y, d, br_nx, last, accept;

    assign x      = a_sh[0];
    assign y      = b_sh[0];
    assign d      = x ^ y ^ br;
    assign br_nx  = (~x & y) | (~(x ^ y) & br);
    assign last   = (cnt == CW'(WIDTH - 1));
    // DONE accepts a new request just like IDLE, giving back-to-back operation
    assign accept = start && (state == IDLE || state == DONE);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            r_sh <= '0;
            br   <= bin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            br   <= br_nx;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff <= {d, r_sh[WIDTH-1:1]};
                bout <= br_nx;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept because the shift registers lose them during SHIFT
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == SHIFT && last) begin
            ovf <= (a_msb != b_msb) && (d != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [7:0] aa, input logic [7:0] bb, input logic bi);
        @(negedge clk);
        a = aa; b = bb; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    endtask

    // Returns cycles counted from the first SHIFT cycle (1) up to the done cycle
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input int lat, input logic [7:0] ed, input logic eb);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 9", name, lat);
        end
        checks++;
        if (diff !== ed) begin
            errors++;
            $display("FAIL %s diff: got %h expected %h", name, diff, ed);
        end
        checks++;
        if (bout !== eb) begin
            errors++;
            $display("FAIL %s bout: got %b expected %b", name, bout, eb);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, bout} !== 3'b000 || diff !== 8'h00) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b expected 0 0 00 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        launch(8'h05, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic busy cycle %0d: got busy=%b done=%b expected 1 0", i, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic done cycle: got busy=%b done=%b expected 0 1", busy, done);
        end
        wait_done(lat);
        check_result("basic", 9, 8'h02, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic done pulse width: got %b expected 0", done);
        end
    endtask

    task automatic test_borrow_hold;
        int lat;
        launch(8'h03, 8'h05, 1'b0);
        wait_done(lat);
        check_result("borrow", lat, 8'hFE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (diff !== 8'hFE || bout !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got diff=%h bout=%b done=%b expected FE 1 0", i, diff, bout, done);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(8'h00, 8'h00, 1'b1);
        wait_done(lat);
        check_result("bin_wrap", lat, 8'hFF, 1'b1);
        a = 8'hA5; b = 8'h5A; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        wait_done(lat);
        check_result("back_to_back", lat, 8'h4B, 1'b0);
    endtask

    task automatic test_ignore_start;
        int lat;
        launch(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_result("ignore_start", lat, 8'h0F, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start queued op cycle %0d: got busy=%b done=%b expected 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        launch(8'h80, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bout} !== 3'b000 || diff !== 8'h00) begin
            errors++;
            $display("FAIL abort: got busy=%b done=%b diff=%h bout=%b expected 0 0 00 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort stray activity cycle %0d: got busy=%b done=%b expected 0 0", i, busy, done);
            end
        end
        launch(8'h05, 8'h03, 1'b0);
        wait_done(lat);
        check_result("after_abort", lat, 8'h02, 1'b0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat;
        launch(8'h80, 8'h01, 1'b0);
        wait_done(lat);
        check_result("ovf_set", lat, 8'h7F, 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set flag: got %b expected 1", ovf);
        end
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(lat);
        check_result("ovf_clr", lat, 8'h7E, 1'b0);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr flag: got %b expected 0", ovf);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_borrow_hold;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor; the inverse operation of the team's combinational full adder.
- Computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency: one cell instead of a WIDTH-bit ripple chain.
- start/busy/done handshake; result registers hold until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse; diff/bout valid
- diff  output  WIDTH  registered result a - b - bin (mod 2^WIDTH)
- bout  output  1  registered final borrow-out (1 when a < b + bin, unsigned)
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal shift registers, borrow FF and bit counter cleared.
- States:
  - IDLE: busy=0. On start=1, load a, b and bin into internal shift registers and the borrow FF; clear counter; go to SHIFT.
  - SHIFT: busy=1. Each cycle, with x = a_sh[0], y = b_sh[0], br = borrow FF:
    - d = x ^ y ^ br
    - br_next = (~x & y) | (~(x ^ y) & br)
    - d shifts into the MSB of the result shift register; a_sh and b_sh shift right; counter increments.
    - After the WIDTH-th bit, load diff from the result shift register and bout from br_next; go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled on edge k → done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1: ignored; the operation in flight is not disturbed and no request is queued.
- a, b and bin may change freely after the accepting edge.
- diff and bout change only at the edge that raises done; they hold between operations.
- rst asserted mid-SHIFT: abort immediately; no done pulse; outputs go to reset values.
- Counter width: clog2(WIDTH+1); the counter never wraps during an operation.
- Wrap-around: results are modulo 2^WIDTH. Example: 0x00 - 0x01 gives diff=0xFF, bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists and is registered, updated alongside diff.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands. bin is included in diff.
  - ovf resets to 0.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse → busy for 8 cycles, done pulse the next cycle; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1; diff holds 0xFE for 5 idle cycles afterwards.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then in the DONE cycle, start with a=0xA5, b=0x5A, bin=0 → the next result is diff=0x4B, bout=0, done 9 cycles after the first done.
- During SHIFT of 0x10-0x01, pulse start with a=0xFF, b=0x00 → ignored; result diff=0x0F, bout=0.
- Assert rst on the 4th SHIFT cycle of 0x80-0x01 → busy, done, diff and bout go to 0 immediately; no done pulse follows. A fresh start then completes normally.
- With SERIAL_SUB_OVF_EN: 0x80-0x01 → diff=0x7F, ovf=1, bout=0; 0x7F-0x01 → diff=0x7E, ovf=0.
